// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI controller and its TX/RX FIFOs between requesters.
// A grant covers a whole transaction: chip-select config, TX/RX byte streaming, idle wait.
module spi_xfer_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LEN_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len_i,
  input  logic [NUM_REQ*2-1:0]       req_cs_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  input  logic [NUM_REQ-1:0]         tx_valid_i,
  output logic [NUM_REQ-1:0]         tx_ready_o,
  input  logic [NUM_REQ*8-1:0]       tx_data_i,
  output logic [NUM_REQ-1:0]         rx_valid_o,
  input  logic [NUM_REQ-1:0]         rx_ready_i,
  output logic [7:0]                 rx_data_o,
  output logic                       tx_fifo_wr_o,
  output logic [7:0]                 tx_fifo_wdata_o,
  input  logic                       tx_fifo_full_i,
  output logic                       rx_fifo_rd_o,
  input  logic [7:0]                 rx_fifo_rdata_i,
  input  logic                       rx_fifo_empty_i,
  input  logic                       spi_busy_i,
  output logic                       cfg_we_o,
  output logic [1:0]                 cfg_cs_id_o,
  output logic [1:0]                 cfg_cs_mode_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {StIdle, StCfg, StXfer, StFlush, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [PTR_W-1:0]   r_ptr, w_ptr_d;
  logic [PTR_W-1:0]   r_gnt, w_gnt_d;
  logic [LEN_W-1:0]   r_len, w_len_d;
  logic [1:0]         r_cs, w_cs_d;
  logic               r_cfg_arm, w_cfg_arm_d;
  logic [CNT_W-1:0]   r_tx_cnt, w_tx_cnt_d;
  logic [CNT_W-1:0]   r_rx_cnt, w_rx_cnt_d;

  logic               w_req_found;
  logic [PTR_W-1:0]   w_req_idx;
  logic [LEN_W-1:0]   w_req_len;
  logic [1:0]         w_req_cs;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;
  logic               w_rx_ready;
  logic [CNT_W-1:0]   w_len_ext;
  logic               w_tx_ok;
  logic               w_rx_ok;

  assign w_len_ext = {1'b0, r_len};

  // First requester at or after r_ptr, searching upward with wrap-around.
  always_comb begin
    logic [PTR_W:0] sum;
    w_req_found = 1'b0;
    w_req_idx   = '0;
    sum         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!w_req_found && req_i[sum[PTR_W-1:0]]) begin
        w_req_found = 1'b1;
        w_req_idx   = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_req_len  = '0;
    w_req_cs   = '0;
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    w_rx_ready = 1'b0;
    w_gnt_oh   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == w_req_idx) begin
        w_req_len = req_len_i[i*LEN_W +: LEN_W];
        w_req_cs  = req_cs_i[i*2 +: 2];
      end
      if (PTR_W'(i) == r_gnt) begin
        w_tx_valid  = tx_valid_i[i];
        w_tx_data   = tx_data_i[i*8 +: 8];
        w_rx_ready  = rx_ready_i[i];
        w_gnt_oh[i] = (r_state != StIdle);
      end
    end
  end

  assign w_tx_ok = (r_state == StXfer) && !tx_fifo_full_i && (r_tx_cnt <= w_len_ext);
  assign w_rx_ok = (r_state == StXfer) && !rx_fifo_empty_i && (r_rx_cnt <= w_len_ext);

  always_comb begin
    gnt_o           = w_gnt_oh;
    done_o          = (r_state == StDone) ? w_gnt_oh : '0;
    tx_ready_o      = {NUM_REQ{w_tx_ok}} & w_gnt_oh;
    rx_valid_o      = {NUM_REQ{w_rx_ok}} & w_gnt_oh;
    tx_fifo_wr_o    = w_tx_ok && w_tx_valid;
    tx_fifo_wdata_o = (r_state == StXfer) ? w_tx_data : 8'h00;
    rx_fifo_rd_o    = w_rx_ok && w_rx_ready;
    rx_data_o       = (r_state == StXfer) ? rx_fifo_rdata_i : 8'h00;
    // r_cfg_arm keeps the config strobe at least one cycle behind the grant.
    cfg_we_o        = (r_state == StCfg) && r_cfg_arm && !spi_busy_i;
    cfg_cs_id_o     = r_cs;
    cfg_cs_mode_o   = (r_len != '0) ? 2'b10 : 2'b00;
  end

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_gnt_d     = r_gnt;
    w_len_d     = r_len;
    w_cs_d      = r_cs;
    w_cfg_arm_d = r_cfg_arm;
    w_tx_cnt_d  = r_tx_cnt;
    w_rx_cnt_d  = r_rx_cnt;
    case (r_state)
      StIdle: begin
        if (w_req_found) begin
          w_gnt_d     = w_req_idx;
          w_len_d     = w_req_len;
          w_cs_d      = w_req_cs;
          w_cfg_arm_d = 1'b0;
          w_state_d   = StCfg;
        end
      end
      StCfg: begin
        w_tx_cnt_d  = '0;
        w_rx_cnt_d  = '0;
        w_cfg_arm_d = 1'b1;
        if (cfg_we_o) w_state_d = StXfer;
      end
      StXfer: begin
        if (tx_fifo_wr_o) w_tx_cnt_d = r_tx_cnt + 1'b1;
        if (rx_fifo_rd_o) begin
          w_rx_cnt_d = r_rx_cnt + 1'b1;
          if (r_rx_cnt == w_len_ext) w_state_d = StFlush;
        end
      end
      StFlush: begin
        if (!spi_busy_i) w_state_d = StDone;
      end
      StDone: begin
        w_ptr_d   = (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_len     <= '0;
      r_cs      <= '0;
      r_cfg_arm <= 1'b0;
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
    end else begin
      r_state   <= w_state_d;
      r_ptr     <= w_ptr_d;
      r_gnt     <= w_gnt_d;
      r_len     <= w_len_d;
      r_cs      <= w_cs_d;
      r_cfg_arm <= w_cfg_arm_d;
      r_tx_cnt  <= w_tx_cnt_d;
      r_rx_cnt  <= w_rx_cnt_d;
    end
  end

endmodule
